// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel_writer slice.
// Contents: FSM state encoding, Kbus field slice positions, the saturation
// limit for the event counters and a saturating increment helper.
package pixel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WRITE = 2'd2
  } state_e;

  // Kbus = {X, Y, Colour}
  localparam int unsigned X_HI = 23;
  localparam int unsigned X_LO = 16;
  localparam int unsigned Y_HI = 15;
  localparam int unsigned Y_LO = 8;
  localparam int unsigned C_HI = 7;
  localparam int unsigned C_LO = 0;

  localparam logic [7:0] SAT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == SAT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO buffering pixel commands.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   push, din  - write request and data; ignored when full unless popping
//   pop, dout  - read request and head-of-queue data (dout valid when !empty)
//   full       - registered, occupancy == DEPTH
//   empty      - occupancy == 0
module pixel_fifo
  import pixel_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = full_q;
  assign dout    = mem_q[rd_ptr_q];
  // A push while full is accepted only if the head leaves in the same cycle.
  assign push_ok = push && (!full_q || pop);
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/pixel_writer.sv
// Receiving end of the DPU video-out interface.
// Buffers {X, Y, Colour} pixel commands, converts (X,Y) to a linear
// framebuffer address and writes Colour through a ready/write handshake.
// Off-screen commands are clipped; strobes arriving while full are dropped.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   Kbus, outEnable     - pixel command and its one-cycle strobe
//   full                - command FIFO full
//   fbAddr, fbData      - registered framebuffer write address / colour
//   fbWe, fbReady       - write request; accepted when both are high
//   dropCount           - saturating count of strobes lost to full
//   clipCount           - saturating count of off-screen commands
//   idle                - FIFO empty and FSM in IDLE
module pixel_writer
  import pixel_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SCREEN_W   = 160,
  parameter int unsigned SCREEN_H   = 120,
  parameter int unsigned ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [23:0]       Kbus,
  input  logic              outEnable,
  output logic              full,
  output logic [ADDR_W-1:0] fbAddr,
  output logic [7:0]        fbData,
  output logic              fbWe,
  input  logic              fbReady,
  output logic [7:0]        dropCount,
  output logic [7:0]        clipCount,
  output logic              idle
);

  state_e              state_q, state_d;
  logic [7:0]          hx_q, hx_d, hy_q, hy_d, hc_q, hc_d;
  logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
  logic [7:0]          fb_data_q, fb_data_d;
  logic                fb_we_q, fb_we_d;
  logic [7:0]          drop_q, drop_d, clip_q, clip_d;

  logic [23:0]         fifo_dout;
  logic                fifo_full, fifo_empty, pop;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (24)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (outEnable),
    .pop   (pop),
    .din   (Kbus),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pop = (state_q == IDLE) && !fifo_empty;

  always_comb begin
    state_d   = state_q;
    hx_d      = hx_q;
    hy_d      = hy_q;
    hc_d      = hc_q;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    fb_we_d   = fb_we_q;
    clip_d    = clip_q;
    drop_d    = (outEnable && fifo_full && !pop) ? sat_inc(drop_q) : drop_q;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          hx_d    = fifo_dout[X_HI:X_LO];
          hy_d    = fifo_dout[Y_HI:Y_LO];
          hc_d    = fifo_dout[C_HI:C_LO];
          state_d = CALC;
        end
      end
      CALC: begin
        if ((32'(hx_q) >= SCREEN_W) || (32'(hy_q) >= SCREEN_H)) begin
          clip_d  = sat_inc(clip_q);
          state_d = IDLE;
        end else begin
          fb_addr_d = ADDR_W'(hy_q) * ADDR_W'(SCREEN_W) + ADDR_W'(hx_q);
          fb_data_d = hc_q;
          fb_we_d   = 1'b1;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        if (fbReady) begin
          fb_we_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        fb_we_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hx_q      <= '0;
      hy_q      <= '0;
      hc_q      <= '0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
      fb_we_q   <= 1'b0;
      drop_q    <= '0;
      clip_q    <= '0;
    end else begin
      state_q   <= state_d;
      hx_q      <= hx_d;
      hy_q      <= hy_d;
      hc_q      <= hc_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
      fb_we_q   <= fb_we_d;
      drop_q    <= drop_d;
      clip_q    <= clip_d;
    end
  end

  assign full      = fifo_full;
  assign fbAddr    = fb_addr_q;
  assign fbData    = fb_data_q;
  assign fbWe      = fb_we_q;
  assign dropCount = drop_q;
  assign clipCount = clip_q;
  assign idle      = fifo_empty && (state_q == IDLE);

endmodule

// File: tb/tb_pixel_writer.sv
// Scoreboard bench for pixel_writer: stimulus pushes expected framebuffer
// writes into a queue; the monitor pops and compares on every accepted write.
module tb_pixel_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] Kbus;
  logic        outEnable;
  logic        full;
  logic [14:0] fbAddr;
  logic [7:0]  fbData;
  logic        fbWe;
  logic        fbReady;
  logic [7:0]  dropCount;
  logic [7:0]  clipCount;
  logic        idle;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [14:0] addr;
    logic [7:0]  data;
  } wr_t;
  wr_t exp_q[$];

  pixel_writer #(
    .FIFO_DEPTH (4),
    .SCREEN_W   (160),
    .SCREEN_H   (120),
    .ADDR_W     (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Kbus      (Kbus),
    .outEnable (outEnable),
    .full      (full),
    .fbAddr    (fbAddr),
    .fbData    (fbData),
    .fbWe      (fbWe),
    .fbReady   (fbReady),
    .dropCount (dropCount),
    .clipCount (clipCount),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle strobe; the expected write is queued only when the bench
  // knows the command will reach the framebuffer.
  task automatic strobe(input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] c, input logic [14:0] exp_addr,
                        input bit will_write);
    wr_t w;
    Kbus      = {x, y, c};
    outEnable = 1'b1;
    if (will_write) begin
      w.addr = exp_addr;
      w.data = c;
      exp_q.push_back(w);
    end
    tick(1);
    outEnable = 1'b0;
  endtask

  // Monitor: every accepted write must match the head of the scoreboard.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (!rst && fbWe && fbReady) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h, none expected", fbAddr, fbData);
        end else begin
          w = exp_q.pop_front();
          check("write_addr", 32'(fbAddr), 32'(w.addr));
          check("write_data", 32'(fbData), 32'(w.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [14:0] s_addr;
    logic [7:0]  s_data;
    int          guard;

    rst = 1'b1; Kbus = '0; outEnable = 1'b0; fbReady = 1'b1;
    tick(2);
    rst = 1'b0;

    // Reset state
    check("rst_fbWe",   32'(fbWe),      32'd0);
    check("rst_fbAddr", 32'(fbAddr),    32'd0);
    check("rst_fbData", 32'(fbData),    32'd0);
    check("rst_drop",   32'(dropCount), 32'd0);
    check("rst_clip",   32'(clipCount), 32'd0);
    check("rst_full",   32'(full),      32'd0);
    check("rst_idle",   32'(idle),      32'd1);

    // Single pixel: strobe in cycle t, fbWe high in t+3 only
    strobe(8'd10, 8'd5, 8'h3C, 15'd810, 1'b1);   // now in t+1
    check("lat_t1_we", 32'(fbWe), 32'd0);
    tick(2);                                      // t+3
    check("lat_t3_we",   32'(fbWe),   32'd1);
    check("lat_t3_addr", 32'(fbAddr), 32'd810);
    check("lat_t3_data", 32'(fbData), 32'h3C);
    tick(1);
    check("lat_t4_we",   32'(fbWe), 32'd0);
    check("single_idle", 32'(idle), 32'd1);

    // Clipping
    strobe(8'd200, 8'd3, 8'h11, 15'd0, 1'b0);
    tick(4);
    check("clip_x", 32'(clipCount), 32'd1);
    strobe(8'd0, 8'd120, 8'h22, 15'd0, 1'b0);
    tick(4);
    check("clip_y",    32'(clipCount), 32'd2);
    check("clip_idle", 32'(idle),      32'd1);
    // Corner pixel just inside the screen
    strobe(8'd159, 8'd119, 8'h5A, 15'd19199, 1'b1);
    tick(5);
    check("corner_clip", 32'(clipCount), 32'd2);

    // Overflow: first strobe goes to the holding register, next four fill
    // the FIFO, the sixth is dropped.
    fbReady = 1'b0;
    for (int i = 0; i < 6; i++)
      strobe(8'(i), 8'(i + 1), 8'(8'h10 + i), 15'((i + 1) * 160 + i), i < 5);
    check("ovf_full", 32'(full),      32'd1);
    check("ovf_drop", 32'(dropCount), 32'd1);
    check("ovf_we",   32'(fbWe),      32'd1);

    // Stall: outputs frozen while fbReady is low
    s_addr = fbAddr;
    s_data = fbData;
    check("stall_addr0", 32'(s_addr), 32'd160);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("stall_hold", {fbWe, 8'(fbData), 15'(fbAddr)}, {1'b1, s_data, s_addr});
    end

    // Accept one write; the following cycle is the IDLE pop with FIFO full,
    // where a strobe must be accepted rather than dropped.
    fbReady = 1'b1;
    tick(1);
    fbReady = 1'b0;
    strobe(8'd50, 8'd60, 8'hAB, 15'd9650, 1'b1);
    check("pp_full", 32'(full),      32'd1);
    check("pp_drop", 32'(dropCount), 32'd1);

    // Drain remaining entries in order
    fbReady = 1'b1;
    guard = 0;
    while (!(idle && exp_q.size() == 0) && guard < 100) begin
      tick(1);
      guard++;
    end
    check("drain_done", 32'(guard < 100), 32'd1);
    check("drain_full", 32'(full),        32'd0);

    // Reset mid-write with two entries buffered
    fbReady = 1'b0;
    strobe(8'd1, 8'd1, 8'h01, 15'd0, 1'b0);
    strobe(8'd2, 8'd2, 8'h02, 15'd0, 1'b0);
    strobe(8'd3, 8'd3, 8'h03, 15'd0, 1'b0);
    check("mid_we",   32'(fbWe), 32'd1);
    check("mid_idle", 32'(idle), 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mrst_we",   32'(fbWe),      32'd0);
    check("mrst_idle", 32'(idle),      32'd1);
    check("mrst_drop", 32'(dropCount), 32'd0);
    check("mrst_clip", 32'(clipCount), 32'd0);
    check("mrst_full", 32'(full),      32'd0);
    fbReady = 1'b1;
    tick(10);
    check("mrst_quiet_we", 32'(fbWe), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
